// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side GPR hazard tracker for a dual-issue pipeline.
// Each GPR holds a countdown of advancing cycles until its pending result
// becomes bypassable. The all-ones value (LONG) parks the register until the
// multi-cycle unit reports completion through long_done/long_addr.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic                flush,
  input  logic                m_valid,
  input  logic [4:0]          m_rs,
  input  logic [4:0]          m_rt,
  input  logic                m_dest_en,
  input  logic [4:0]          m_dest,
  input  logic [CNT_W-1:0]    m_lat,
  input  logic                s_valid,
  input  logic [4:0]          s_rs,
  input  logic [4:0]          s_rt,
  input  logic                s_dest_en,
  input  logic [4:0]          s_dest,
  input  logic [CNT_W-1:0]    s_lat,
  input  logic                long_done,
  input  logic [4:0]          long_addr,
  output logic                issue_stall,
  output logic                slave_hold,
  output logic [NUM_REGS-1:0] pending_mask
);

  localparam logic [CNT_W-1:0] LONG = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  logic m_haz_s;
  logic s_haz_s;
  logic intra_s;
  logic m_fire_s;
  logic s_fire_s;

  // Hazard detection, intra-pair dependency and fire qualification.
  always_comb begin
    m_haz_s = m_valid & ((cnt_q[m_rs] != ZERO) | (cnt_q[m_rt] != ZERO));
    s_haz_s = s_valid & ((cnt_q[s_rs] != ZERO) | (cnt_q[s_rt] != ZERO));
    // The slave reads or overwrites the master's destination in the same pair.
    intra_s = s_valid & m_valid & m_dest_en & (m_dest != 5'd0)
            & ((s_rs == m_dest) | (s_rt == m_dest) | (s_dest_en & (s_dest == m_dest)));
    issue_stall = m_haz_s | (s_haz_s & ~intra_s);
    slave_hold  = ~issue_stall & intra_s;
    m_fire_s    = m_valid & advance & ~issue_stall & ~flush;
    s_fire_s    = m_fire_s & s_valid & ~slave_hold;
  end

  // Per-register next countdown: flush, slave issue, master issue, long completion, decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = ZERO;
      end else if (flush) begin
        cnt_d[r] = ZERO;
      end else if (s_fire_s & s_dest_en & (s_dest == 5'(r))) begin
        // Slave is the younger writer, so it governs a shared destination.
        cnt_d[r] = s_lat;
      end else if (m_fire_s & m_dest_en & (m_dest == 5'(r))) begin
        cnt_d[r] = m_lat;
      end else if (long_done & (long_addr == 5'(r)) & (cnt_q[r] == LONG)) begin
        cnt_d[r] = ZERO;
      end else if (advance & (cnt_q[r] != ZERO) & (cnt_q[r] != LONG)) begin
        cnt_d[r] = cnt_q[r] - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Countdown state; reset clears every entry asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= ZERO;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Debug/perf view of which registers still have a result in flight.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt_q[r] != ZERO);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        advance;
  logic        flush;
  logic        m_valid;
  logic [4:0]  m_rs;
  logic [4:0]  m_rt;
  logic        m_dest_en;
  logic [4:0]  m_dest;
  logic [1:0]  m_lat;
  logic        s_valid;
  logic [4:0]  s_rs;
  logic [4:0]  s_rt;
  logic        s_dest_en;
  logic [4:0]  s_dest;
  logic [1:0]  s_lat;
  logic        long_done;
  logic [4:0]  long_addr;
  logic        issue_stall;
  logic        slave_hold;
  logic [31:0] pending_mask;

  int n_cmp;
  int n_fail;

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush),
    .m_valid(m_valid), .m_rs(m_rs), .m_rt(m_rt), .m_dest_en(m_dest_en),
    .m_dest(m_dest), .m_lat(m_lat),
    .s_valid(s_valid), .s_rs(s_rs), .s_rt(s_rt), .s_dest_en(s_dest_en),
    .s_dest(s_dest), .s_lat(s_lat),
    .long_done(long_done), .long_addr(long_addr),
    .issue_stall(issue_stall), .slave_hold(slave_hold), .pending_mask(pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    advance = 1'b0; flush = 1'b0;
    m_valid = 1'b0; m_rs = 5'd0; m_rt = 5'd0; m_dest_en = 1'b0; m_dest = 5'd0; m_lat = 2'd0;
    s_valid = 1'b0; s_rs = 5'd0; s_rt = 5'd0; s_dest_en = 1'b0; s_dest = 5'd0; s_lat = 2'd0;
    long_done = 1'b0; long_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_m(input logic [4:0] dest, input logic [1:0] lat);
    idle();
    advance = 1'b1; m_valid = 1'b1; m_dest_en = 1'b1; m_dest = dest; m_lat = lat;
    #1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0 || issue_stall !== 1'b0 || slave_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mask=%h stall=%b hold=%b, expected 0/0/0", pending_mask, issue_stall, slave_hold);
    end
    issue_m(5'd3, 2'd3);
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL reset_populate: mask=%h expected 00000008", pending_mask);
    end
    m_valid = 1'b1; m_rs = 5'd3;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0 || issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: mask=%h stall=%b, expected 0/0", pending_mask, issue_stall);
    end
    tick();
    rst = 1'b0;
    idle();
    #1;
  endtask

  task automatic test_load_use();
    logic exp_stall [5];
    // advance pattern after issue: 1,1,1 ; expect stall 1,1,0
    issue_m(5'd5, 2'd2);
    for (int c = 0; c < 3; c++) begin
      idle(); advance = 1'b1; m_valid = 1'b1; m_rs = 5'd5;
      #1;
      n_cmp++;
      if (issue_stall !== (c < 2)) begin
        n_fail++;
        $display("FAIL load_use_c%0d: stall=%b expected %b", c, issue_stall, (c < 2));
      end
      tick();
    end
    // second run with a frozen cycle: advance 1,0,1,1 ; expect stall 1,1,1,0
    exp_stall[0] = 1'b1; exp_stall[1] = 1'b1; exp_stall[2] = 1'b1; exp_stall[3] = 1'b0; exp_stall[4] = 1'b0;
    issue_m(5'd5, 2'd2);
    for (int c = 0; c < 4; c++) begin
      idle(); advance = (c != 1); m_valid = 1'b1; m_rt = 5'd5;
      #1;
      n_cmp++;
      if (issue_stall !== exp_stall[c]) begin
        n_fail++;
        $display("FAIL load_use_frz_c%0d: stall=%b expected %b", c, issue_stall, exp_stall[c]);
      end
      tick();
    end
    idle();
    #1;
  endtask

  task automatic test_intra();
    idle();
    advance = 1'b1;
    m_valid = 1'b1; m_dest_en = 1'b1; m_dest = 5'd8; m_lat = 2'd2;
    s_valid = 1'b1; s_rt = 5'd8; s_dest_en = 1'b1; s_dest = 5'd20; s_lat = 2'd1;
    #1;
    n_cmp++;
    if (slave_hold !== 1'b1 || issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL intra_hold: hold=%b stall=%b expected 1/0", slave_hold, issue_stall);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL intra_mask: mask=%h expected 00000100", pending_mask);
    end
    advance = 1'b1;
    tick(); tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL intra_drain: mask=%h expected 00000000", pending_mask);
    end
  endtask

  task automatic test_same_dest();
    idle();
    advance = 1'b1;
    m_valid = 1'b1; m_dest_en = 1'b1; m_dest = 5'd9; m_lat = 2'd0;
    s_valid = 1'b1; s_dest_en = 1'b1; s_dest = 5'd9; s_lat = 2'd1;
    #1;
    n_cmp++;
    if (slave_hold !== 1'b1 || issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_hold: hold=%b stall=%b expected 1/0", slave_hold, issue_stall);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL waw_master_only: mask=%h expected 00000000", pending_mask);
    end
    issue_m(5'd9, 2'd1);
    idle(); m_valid = 1'b1; m_rs = 5'd9;
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0000_0200 || issue_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_replay: mask=%h stall=%b expected 00000200/1", pending_mask, issue_stall);
    end
    advance = 1'b1;
    tick();
    idle(); m_valid = 1'b1; m_rs = 5'd9;
    #1;
    n_cmp++;
    if (issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_release: stall=%b expected 0", issue_stall);
    end
    idle();
    #1;
  endtask

  task automatic test_zero_reg();
    issue_m(5'd0, 2'd2);
    idle(); m_valid = 1'b1; m_rs = 5'd0; m_rt = 5'd0;
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0 || issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg: mask=%h stall=%b expected 0/0", pending_mask, issue_stall);
    end
    idle();
    advance = 1'b1; m_valid = 1'b1; m_dest_en = 1'b0; m_dest = 5'd4; m_lat = 2'd2;
    #1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL dest_en_off: mask=%h expected 00000000", pending_mask);
    end
  endtask

  task automatic test_long();
    int stalls;
    issue_m(5'd10, 2'd3);
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      idle(); advance = 1'b1; m_valid = 1'b1; m_rs = 5'd10;
      #1;
      if (issue_stall === 1'b1) stalls++;
      tick();
    end
    n_cmp++;
    if (stalls !== 20) begin
      n_fail++;
      $display("FAIL long_hold: stalled %0d of 20 cycles, expected 20", stalls);
    end
    idle(); advance = 1'b1; m_valid = 1'b1; m_rs = 5'd10; long_done = 1'b1; long_addr = 5'd10;
    #1;
    tick();
    idle(); advance = 1'b1; m_valid = 1'b1; m_rs = 5'd10;
    #1;
    n_cmp++;
    if (issue_stall !== 1'b0 || pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL long_done: stall=%b mask=%h expected 0/00000000", issue_stall, pending_mask);
    end
    // long_done against a short countdown must be ignored
    issue_m(5'd11, 2'd2);
    idle(); long_done = 1'b1; long_addr = 5'd11;
    #1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL long_done_nonlong: mask=%h expected 00000800", pending_mask);
    end
    advance = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL nonlong_count: mask=%h expected 00000800", pending_mask);
    end
    tick();
    idle();
    #1;
  endtask

  task automatic test_back_to_back();
    issue_m(5'd7, 2'd3);
    issue_m(5'd7, 2'd1);
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL b2b_overwrite: mask=%h expected 00000080", pending_mask);
    end
    advance = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_drain: mask=%h expected 00000000 (LONG not overwritten)", pending_mask);
    end
  endtask

  task automatic test_flush();
    issue_m(5'd13, 2'd3);
    idle();
    advance = 1'b1; flush = 1'b1;
    m_valid = 1'b1; m_dest_en = 1'b1; m_dest = 5'd12; m_lat = 2'd3;
    #1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_clear: mask=%h expected 00000000", pending_mask);
    end
    long_done = 1'b1; long_addr = 5'd12;
    #1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_mask !== 32'h0 || issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_long_done: mask=%h stall=%b expected 0/0", pending_mask, issue_stall);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_intra();
    test_same_dest();
    test_zero_reg();
    test_long();
    test_back_to_back();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
